// File: rtl/lut_config_loader.sv
// Bit-serial LUT configuration loader: assembles a frame in a shadow register and commits it atomically to `values`.
// Optional even-parity check on each frame is enabled by defining LUT_CONFIG_PARITY_EN.
module lut_config_loader #(
    parameter int unsigned INPUTS = 4,
    parameter int unsigned WIDTH  = 1 << INPUTS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cfg_bit,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic [WIDTH-1:0] values,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned IW = (INPUTS > 0) ? INPUTS : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shadow;

    // Single-process FSM; cfg_ready and busy are registered alongside the state they describe.
    always_ff @(posedge clk) begin
        done <= 1'b0;
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            shadow    <= '0;
            values    <= '0;
            cfg_ready <= 1'b0;
            busy      <= 1'b0;
`ifdef LUT_CONFIG_PARITY_EN
            error     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= SHIFT;
                        cnt       <= '0;
                        shadow    <= '0;
                        cfg_ready <= 1'b1;
                        busy      <= 1'b1;
`ifdef LUT_CONFIG_PARITY_EN
                        error     <= 1'b0;
`endif
                    end
                end
                SHIFT: begin
                    // A restart wins over the bit presented in the same cycle.
                    if (start) begin
                        cnt    <= '0;
                        shadow <= '0;
                    end else if (cfg_valid && cfg_ready) begin
                        shadow[cnt[IW-1:0]] <= cfg_bit;
                        cnt                 <= cnt + CW'(1);
                        if (cnt == CW'(WIDTH - 1)) begin
`ifdef LUT_CONFIG_PARITY_EN
                            state     <= PARITY;
`else
                            state     <= COMMIT;
                            cfg_ready <= 1'b0;
`endif
                        end
                    end
                end
`ifdef LUT_CONFIG_PARITY_EN
                PARITY: begin
                    if (start) begin
                        state  <= SHIFT;
                        cnt    <= '0;
                        shadow <= '0;
                    end else if (cfg_valid && cfg_ready) begin
                        cfg_ready <= 1'b0;
                        if (cfg_bit == ^shadow) begin
                            state <= COMMIT;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            error <= 1'b1;
                        end
                    end
                end
`endif
                COMMIT: begin
                    values    <= shadow;
                    done      <= 1'b1;
                    state     <= IDLE;
                    cfg_ready <= 1'b0;
                    busy      <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    cfg_ready <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifndef LUT_CONFIG_PARITY_EN
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_lut_config_loader.sv
// Self-checking bench for lut_config_loader (INPUTS=2): directed frames followed by randomized frames vs a frame-level model.
module tb_lut_config_loader;

    localparam int unsigned INPUTS = 2;
    localparam int unsigned WIDTH  = 4;
`ifdef LUT_CONFIG_PARITY_EN
    localparam int unsigned PBITS = 1;
`else
    localparam int unsigned PBITS = 0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             cfg_bit;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] values;
    logic             busy;
    logic             done;
    logic             error;

    lut_config_loader #(.INPUTS(INPUTS)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_bit   (cfg_bit),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .values    (values),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [WIDTH-1:0] m_values;
    logic             m_error;
    int               gaps[WIDTH+1];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic rdy, input logic bsy, input logic dn);
        chk({tag, ".values"}, 32'(values), 32'(m_values));
        chk({tag, ".cfg_ready"}, 32'(cfg_ready), 32'(rdy));
        chk({tag, ".busy"}, 32'(busy), 32'(bsy));
        chk({tag, ".done"}, 32'(done), 32'(dn));
        chk({tag, ".error"}, 32'(error), 32'(m_error));
    endtask

    function automatic logic parity_of(input logic [WIDTH-1:0] d);
        int ones = 0;
        for (int i = 0; i < int'(WIDTH); i++) if (d[i]) ones++;
        return 1'(ones % 2);
    endfunction

    task automatic clear_gaps();
        for (int i = 0; i <= int'(WIDTH); i++) gaps[i] = 0;
    endtask

    // One whole frame: start (with a rejected bit alongside), data LSB first, optional parity, then commit or reject.
    task automatic run_frame(input logic [WIDTH-1:0] data, input logic par,
                             input bit start_in_commit, input bit chain);
        bit ok;
`ifdef LUT_CONFIG_PARITY_EN
        ok = (par == parity_of(data));
`else
        ok = 1'b1;
`endif
        start = 1'b1; cfg_valid = 1'b1; cfg_bit = 1'b1;
        step();
        start = 1'b0; cfg_valid = 1'b0;
        m_error = 1'b0;
        chk_all("start", 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < int'(WIDTH + PBITS); k++) begin
            for (int g = 0; g < gaps[k]; g++) begin
                cfg_valid = 1'b0; cfg_bit = 1'($urandom);
                step();
                chk_all("gap", 1'b1, 1'b1, 1'b0);
            end
            cfg_valid = 1'b1;
            cfg_bit   = (k < int'(WIDTH)) ? data[k] : par;
            step();
            cfg_valid = 1'b0; cfg_bit = 1'($urandom);
            if (k < int'(WIDTH + PBITS) - 1) chk_all("shift", 1'b1, 1'b1, 1'b0);
        end
        if (ok) begin
            chk_all("pre_commit", 1'b0, 1'b1, 1'b0);
            start = start_in_commit;
            step();
            start = 1'b0;
            m_values = data;
            chk_all("commit", 1'b0, 1'b0, 1'b1);
        end else begin
            m_error = 1'b1;
            chk_all("parity_reject", 1'b0, 1'b0, 1'b0);
            step();
            chk_all("post_reject", 1'b0, 1'b0, 1'b0);
        end
        if (!chain) begin
            step();
            chk_all("idle", 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic send_partial(input int nbits);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            cfg_valid = 1'b1; cfg_bit = 1'b1;
            step();
        end
        cfg_valid = 1'b0;
        chk_all("partial", 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        logic [WIDTH-1:0] d;
        logic             p;
        rst = 1'b1; start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
        m_values = '0; m_error = 1'b0;
        clear_gaps();

        step(); step();
        chk_all("reset", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        chk_all("reset_idle", 1'b0, 1'b0, 1'b0);

        // Back-to-back bits 1,0,1,1
        run_frame(4'b1101, parity_of(4'b1101), 1'b0, 1'b0);

        // Three idle cycles between the second and third bit
        gaps[2] = 3;
        run_frame(4'b1101, parity_of(4'b1101), 1'b0, 1'b0);
        clear_gaps();

        // Restart after two bits; old contents stay until the new commit
        send_partial(2);
        run_frame(4'b0110, parity_of(4'b0110), 1'b0, 1'b0);

        // Reset mid-frame clears the committed contents
        run_frame(4'b1101, parity_of(4'b1101), 1'b0, 1'b0);
        send_partial(2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_values = '0; m_error = 1'b0;
        chk_all("mid_reset", 1'b0, 1'b0, 1'b0);
        step();
        chk_all("after_reset", 1'b0, 1'b0, 1'b0);

        // start during COMMIT is ignored; start in the done cycle begins a new frame
        run_frame(4'b1001, parity_of(4'b1001), 1'b1, 1'b0);
        run_frame(4'b0101, parity_of(4'b0101), 1'b0, 1'b1);
        run_frame(4'b1110, parity_of(4'b1110), 1'b0, 1'b0);

`ifdef LUT_CONFIG_PARITY_EN
        run_frame(4'b0011, 1'b0, 1'b0, 1'b0);
        run_frame(4'b0001, 1'b0, 1'b0, 1'b0);
        run_frame(4'b1010, 1'b0, 1'b0, 1'b0);
`endif

        for (int it = 0; it < 40; it++) begin
            d = WIDTH'($urandom);
            p = parity_of(d);
            if ($urandom_range(0, 3) == 0) p = ~p;
            for (int i = 0; i <= int'(WIDTH); i++) gaps[i] = int'($urandom_range(0, 2));
            if ($urandom_range(0, 4) == 0) send_partial(int'($urandom_range(0, WIDTH - 1)));
            run_frame(d, p, 1'($urandom), 1'($urandom));
        end
        step();
        chk("final.done", 32'(done), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
